ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILT, default 4: consecutive identical synchronized ps2_clk samples needed to change the filtered clock level.
REQ-002 Parameter TIMEOUT, default 1024: clk_sys cycles without a filtered falling edge before a partial frame is aborted.
REQ-003 clk_sys  in  1  single clock for all logic; the block has one clock.
REQ-004 rst_n  in  1  reset, synchronous to clk_sys, active-low.
REQ-005 ps2_clk  in  1  PS/2 keyboard clock from mist_io ps2_kbd_clk; idle high; asynchronous.
REQ-006 ps2_data  in  1  PS/2 keyboard data from mist_io ps2_kbd_data; asynchronous.
REQ-007 key_data  out  10  FIFO head, packed as {ext, rel, code[7:0]}.
REQ-008 key_valid  out  1  FIFO non-empty; key_data is valid.
REQ-009 key_ready  in  1  consumer pop; a pop occurs when key_valid and key_ready are both high in a cycle.
REQ-010 frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.
REQ-011 overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer with reset value 1.
REQ-013 The filtered clock (reset 1) SHALL change level only after FILT consecutive synchronized samples differ from its current level; shorter pulses SHALL be ignored.
REQ-014 The synchronized ps2_data SHALL be sampled in the cycle the filtered clock falls (cycle N).
REQ-015 FSM states are IDLE, DATA, PARITY and STOP; the reset state is IDLE.
- IDLE: an edge with data=0 goes to DATA with bit count 0; an edge with data=1 is ignored.
- DATA: shift the data LSB-first; after the 8th bit go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: go to IDLE.
REQ-016 A frame SHALL be good when the count of ones in the 8 data bits plus the parity bit is odd and the stop bit is 1; otherwise the frame is bad.
REQ-017 On a bad frame, frame_err SHALL pulse at N+1, the ext/rel prefix flags SHALL clear, and no event SHALL be generated.
REQ-018 If not in IDLE and TIMEOUT cycles pass without a filtered falling edge, the FSM SHALL return to IDLE.
- frame_err SHALL pulse once.
- The prefix flags SHALL clear.
- The timeout counter SHALL reset on every filtered falling edge and whenever the FSM is in IDLE.
REQ-019 Good-frame byte decode:
- 0xE0 SHALL set ext.
- 0xF0 SHALL set rel.
- Any other byte SHALL produce the event {ext, rel, byte} and clear both flags.
- The flags SHALL persist across prefix bytes in either order.
REQ-020 An event SHALL be written to the FIFO at N+1, where N is the stop-bit edge; key_valid SHALL be high at N+2 when the FIFO was empty (no fall-through).
REQ-021 The FIFO SHALL be 4 entries deep, first-in first-out, with 2-bit wrapping read and write pointers and a 3-bit occupancy count.
REQ-022 A write while full with no pop SHALL drop the event and set overflow; overflow SHALL clear only on reset.
REQ-023 A simultaneous write and pop while full SHALL perform both operations, with no drop and no overflow.
REQ-024 A simultaneous write and pop on an empty FIFO SHALL perform the write only, since key_valid is low.
REQ-025 key_data SHALL present the head entry whenever key_valid=1; its value is don't-care when key_valid=0.

Reset
REQ-026 rst_n=0 sampled at a clk_sys edge SHALL set all of the following:
- FSM to IDLE, with bit count, shift register, timeout counter and prefix flags cleared.
- Synchronizers and filtered clock to 1.
- FIFO empty.
- key_valid=0, key_data=0, frame_err=0, overflow=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, the next start bit SHALL be decoded normally, with no error pulse.
REQ-028 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-029 A frame for 0x1C with a half-period of 101 cycles and key_ready=1 -> key_data=0x01C and key_valid high for exactly one cycle, at N+2 after the stop edge.
REQ-030 Frames E0, F0, 75 -> exactly one entry, key_data=0x375; frames F0, 1C -> 0x11C.
REQ-031 A 0x1C frame with the parity bit inverted -> frame_err pulse, no entry; the following good 0x1C frame -> 0x01C.
REQ-032 A frame stopped after 4 data bits, idle for more than 1024 cycles -> one frame_err pulse, FSM in IDLE; the next 0x29 frame -> 0x029.
REQ-033 key_ready=0 with codes 0x16, 0x1E, 0x26, 0x25, 0x2E -> overflow=1; draining yields 0x016, 0x01E, 0x026, 0x025, then key_valid=0.
REQ-034 A 2-cycle low glitch on ps2_clk in IDLE -> no state change; rst_n pulsed after 5 data bits, then a 0x1C frame -> 0x01C and no frame_err.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// Keyboard event stream: FIFO head, handshake, and the error/overflow status lines.
interface ps2_kbd_rx_if;
   logic [9:0] key_data;
   logic       key_valid;
   logic       key_ready;
   logic       frame_err;
   logic       overflow;

   modport master (
      output key_data,
      output key_valid,
      output frame_err,
      output overflow,
      input  key_ready
   );

   modport slave (
      input  key_data,
      input  key_valid,
      input  frame_err,
      input  overflow,
      output key_ready
   );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, decodes
// 11-bit frames, folds E0/F0 prefixes into {ext, rel, code} events and queues
// them in a 4-entry FIFO.
module ps2_kbd_rx #(
   parameter int unsigned FILT    = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   ps2_kbd_rx_if.master kbd
);

   localparam int unsigned FW = $clog2(FILT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   // synchronizer / filter
   logic          clk_meta, clk_sync;
   logic          dat_meta, dat_sync;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          filt_flip;
   logic          fall;

   // frame FSM
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          ext_q, ext_d;
   logic          rel_q, rel_d;
   logic          wr_en_q, wr_en_d;
   logic [9:0]    wr_data_q, wr_data_d;
   logic          err_q, err_d;
   logic          timed_out;

   // FIFO
   logic [9:0]    mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          ovf_q;

   // Two-flop synchronizers on both PS/2 lines, idling high.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         dat_meta <= ps2_data;
         dat_sync <= dat_meta;
      end
   end

   // The filtered level flips on the FILT-th consecutive differing sample.
   assign filt_flip = (clk_sync != filt_clk) && (filt_cnt == FW'(FILT - 1));
   assign fall      = filt_flip && filt_clk;

   // Glitch filter on the synchronized PS/2 clock.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_sync == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_flip) begin
         filt_clk <= clk_sync;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign timed_out = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT - 1));

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         to_cnt_q  <= to_cnt_d;
         ext_q     <= ext_d;
         rel_q     <= rel_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   // Next-state, frame check, prefix decode and timeout abort.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      ext_d     = ext_q;
      rel_d     = rel_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;

      if (state_q == IDLE || fall) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      if (timed_out) begin
         state_d  = IDLE;
         err_d    = 1'b1;
         ext_d    = 1'b0;
         rel_d    = 1'b0;
         to_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fall && !dat_sync) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_d   = {dat_sync, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = PARITY;
                  end
               end
            end
            PARITY: begin
               if (fall) begin
                  par_d   = dat_sync;
                  state_d = STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  state_d = IDLE;
                  if ((^{shift_q, par_q}) && dat_sync) begin
                     if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                     end else if (shift_q == 8'hF0) begin
                        rel_d = 1'b1;
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {ext_q, rel_q, shift_q};
                        ext_d     = 1'b0;
                        rel_d     = 1'b0;
                     end
                  end else begin
                     err_d = 1'b1;
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign full  = (count == 3'd4);
   assign empty = (count == 3'd0);
   assign pop   = !empty && kbd.key_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push  = wr_en_q && (!full || pop);

   // Event FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data_q;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count + 3'(push) - 3'(pop);
         if (wr_en_q && full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign kbd.key_valid = !empty;
   assign kbd.key_data  = empty ? '0 : mem[rd_ptr];
   assign kbd.frame_err = err_q;
   assign kbd.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Randomized and directed bench for ps2_kbd_rx against a queue-based event model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   logic clk_sys = 1'b0;
   logic rst_n;
   logic ps2_clk;
   logic ps2_data;

   ps2_kbd_rx_if kbd ();

   ps2_kbd_rx #(.FILT(4), .TIMEOUT(1024)) dut (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (kbd)
   );

   always #5 clk_sys = ~clk_sys;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;

   // reference model state
   logic [9:0]  exp_q [$];
   bit          m_ext, m_rel;
   bit          exp_ovf;
   bit          hold_ready;
   int unsigned exp_err;
   int unsigned err_seen;

   // key_valid run tracking
   int unsigned v_run, last_width, last_rise, stop_fall_cyc;
   bit          rand_ready;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural decoder: one complete frame seen by the keyboard.
   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         exp_err++;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else begin
         if (hold_ready && exp_q.size() >= 4) exp_ovf = 1'b1;
         else exp_q.push_back({m_ext, m_rel, b});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ext   = 1'b0;
      m_rel   = 1'b0;
      exp_ovf = 1'b0;
   endtask

   // Drive one PS/2 frame; ndata < 8 truncates after that many data bits.
   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                             input int unsigned hp, input int unsigned ndata);
      logic [10:0] bits;
      int unsigned nbits;
      if (ndata >= 8) model_frame(b, !flip_par && !bad_stop);
      bits[0]    = 1'b0;
      bits[8:1]  = b;
      bits[9]    = (~^b) ^ flip_par;
      bits[10]   = ~bad_stop;
      nbits      = (ndata >= 8) ? 11 : 1 + ndata;
      for (int i = 0; i < int'(nbits); i++) begin
         ps2_data = bits[i];
         repeat (hp) @(posedge clk_sys);
         #1;
         ps2_clk = 1'b0;
         if (i == 10) stop_fall_cyc = cyc;
         repeat (hp) @(posedge clk_sys);
         #1;
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (hp) @(posedge clk_sys);
      #1;
   endtask

   task automatic drain(input string tag);
      int unsigned t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk_sys);
         t++;
      end
      #1;
      check_val(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Consumer side: compare every pop with the model queue, count error pulses.
   always @(negedge clk_sys) begin
      if (rst_n) begin
         if (kbd.frame_err) err_seen++;
         if (kbd.key_valid && kbd.key_ready) begin
            if (exp_q.size() == 0) check_val("pop_model_empty", 32'(exp_q.size()), 32'd1);
            else check_val("key_data", 32'(kbd.key_data), 32'(exp_q.pop_front()));
         end
      end
      if (kbd.key_valid) begin
         if (v_run == 0) last_rise = cyc;
         v_run++;
      end else if (v_run != 0) begin
         last_width = v_run;
         v_run      = 0;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      int unsigned d;
      logic [7:0]  b;
      logic [7:0]  ovf_codes [5];
      ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

      rst_n         = 1'b0;
      ps2_clk       = 1'b1;
      ps2_data      = 1'b1;
      kbd.key_ready = 1'b1;
      hold_ready    = 1'b0;
      rand_ready    = 1'b0;
      model_reset();
      repeat (4) @(posedge clk_sys);
      #1;
      check_val("rst_valid", 32'(kbd.key_valid), 32'd0);
      check_val("rst_data", 32'(kbd.key_data), 32'd0);
      check_val("rst_err", 32'(kbd.frame_err), 32'd0);
      check_val("rst_ovf", 32'(kbd.overflow), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk_sys);
      #1;

      // single 0x1C at a 101-cycle half period; valid for one cycle shortly after stop edge
      send_frame(8'h1C, 1'b0, 1'b0, 101, 8);
      drain("q_1c");
      d = last_rise - stop_fall_cyc;
      check_val("valid_width", 32'(last_width), 32'd1);
      check_val("valid_latency_ok", 32'(d >= 3 && d <= 12), 32'd1);

      // prefixes
      send_frame(8'hE0, 1'b0, 1'b0, 40, 8);
      send_frame(8'hF0, 1'b0, 1'b0, 40, 8);
      send_frame(8'h75, 1'b0, 1'b0, 40, 8);
      send_frame(8'hF0, 1'b0, 1'b0, 40, 8);
      send_frame(8'h1C, 1'b0, 1'b0, 40, 8);
      drain("q_prefix");

      // parity error then good frame
      send_frame(8'h1C, 1'b1, 1'b0, 40, 8);
      check_val("err_parity", 32'(err_seen), 32'(exp_err));
      send_frame(8'h1C, 1'b0, 1'b0, 40, 8);
      drain("q_after_parity");

      // stop-bit error
      send_frame(8'h5A, 1'b0, 1'b1, 40, 8);
      check_val("err_stop", 32'(err_seen), 32'(exp_err));

      // truncated frame followed by timeout
      send_frame(8'h55, 1'b0, 1'b0, 40, 4);
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
      repeat (1200) @(posedge clk_sys);
      #1;
      check_val("err_timeout", 32'(err_seen), 32'(exp_err));
      send_frame(8'h29, 1'b0, 1'b0, 40, 8);
      drain("q_after_timeout");

      // short glitch on ps2_clk while idle
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      ps2_clk = 1'b1;
      repeat (30) @(posedge clk_sys);
      #1;
      check_val("glitch_err", 32'(err_seen), 32'(exp_err));
      check_val("glitch_valid", 32'(kbd.key_valid), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b0, 40, 8);
      drain("q_after_glitch");

      // reset in mid-frame
      send_frame(8'h33, 1'b0, 1'b0, 40, 5);
      rst_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      model_reset();
      rst_n = 1'b1;
      check_val("midrst_valid", 32'(kbd.key_valid), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b0, 40, 8);
      drain("q_after_midrst");
      check_val("midrst_err", 32'(err_seen), 32'(exp_err));

      // FIFO overflow with consumer stalled
      hold_ready    = 1'b1;
      kbd.key_ready = 1'b0;
      foreach (ovf_codes[i]) send_frame(ovf_codes[i], 1'b0, 1'b0, 30, 8);
      check_val("ovf_flag", 32'(kbd.overflow), 32'(exp_ovf));
      check_val("ovf_valid", 32'(kbd.key_valid), 32'd1);
      check_val("ovf_head", 32'(kbd.key_data), 32'(exp_q[0]));
      hold_ready    = 1'b0;
      kbd.key_ready = 1'b1;
      drain("q_ovf_drain");
      repeat (2) @(posedge clk_sys);
      #1;
      check_val("ovf_empty", 32'(kbd.key_valid), 32'd0);

      // randomized frames with a randomly stalling consumer
      rand_ready = 1'b1;
      fork
         begin
            while (rand_ready) begin
               @(posedge clk_sys);
               #1;
               kbd.key_ready = 1'($urandom % 2);
            end
         end
      join_none
      for (int n = 0; n < 25; n++) begin
         case ($urandom % 8)
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            default: b = 8'($urandom % 256);
         endcase
         send_frame(b, ($urandom % 8) == 0, ($urandom % 16) == 1,
                    $urandom_range(60, 15), 8);
         repeat ($urandom % 50) @(posedge clk_sys);
         #1;
      end
      rand_ready = 1'b0;
      @(posedge clk_sys);
      #2;
      kbd.key_ready = 1'b1;
      drain("q_random");
      repeat (4) @(posedge clk_sys);
      #1;
      check_val("final_err_count", 32'(err_seen), 32'(exp_err));
      check_val("final_ovf", 32'(kbd.overflow), 32'(exp_ovf));
      check_val("final_valid", 32'(kbd.key_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
